// File: rtl/sqrt_controller_if.sv
// sqrt_controller_if: requester/core/consumer handshake bundle of the square-root sequencer
interface sqrt_controller_if #(parameter int CNT_W = 6);
  logic             i_start;
  logic             i_in_type;
  logic             i_run;
  logic             i_out_ack;
  logic             i_core_zero_rem;
  logic             o_ready;
  logic             o_ld_reg;
  logic             o_core_init;
  logic             o_core_step;
  logic [CNT_W-1:0] o_step_idx;
  logic             o_res_ld;
  logic [CNT_W-1:0] o_rem_steps;
  logic             o_type_q;
  logic             o_bypass;
  logic             o_out_valid;
  logic             o_busy;
  modport slave (
    input  i_start, i_in_type, i_run, i_out_ack, i_core_zero_rem,
    output o_ready, o_ld_reg, o_core_init, o_core_step, o_step_idx, o_res_ld,
           o_rem_steps, o_type_q, o_bypass, o_out_valid, o_busy
  );
  modport master (
    output i_start, i_in_type, i_run, i_out_ack, i_core_zero_rem,
    input  o_ready, o_ld_reg, o_core_init, o_core_step, o_step_idx, o_res_ld,
           o_rem_steps, o_type_q, o_bypass, o_out_valid, o_busy
  );
endinterface

// File: rtl/sqrt_controller.sv
// sqrt_controller: sequencing FSM for the iterative square-root core
// Optional early exit on zero remainder: define SQRT_CTRL_EARLY_EXIT_EN
module sqrt_controller #(
  parameter int SP_ITERS = 25,
  parameter int DP_ITERS = 54,
  parameter int CNT_W    = 6
) (
  input logic         clk,
  input logic         rst_n,
  sqrt_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INIT, ITER, NORM, DONE} state_t;
  localparam logic [CNT_W-1:0] SP_LAST = CNT_W'(SP_ITERS - 1);
  localparam logic [CNT_W-1:0] DP_LAST = CNT_W'(DP_ITERS - 1);
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic             r_type, w_type_nxt;
  logic             r_bypass, w_bypass_nxt;
  logic             w_early;
`ifdef SQRT_CTRL_EARLY_EXIT_EN
  assign w_early = bus.i_core_zero_rem;
`else
  assign w_early = 1'b0 & bus.i_core_zero_rem;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_rem    <= '0;
      r_type   <= 1'b0;
      r_bypass <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_rem    <= w_rem_nxt;
      r_type   <= w_type_nxt;
      r_bypass <= w_bypass_nxt;
    end
  end
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_rem_nxt    = r_rem;
    w_type_nxt   = r_type;
    w_bypass_nxt = r_bypass;
    case (r_state)
      IDLE: if (bus.i_start) begin
        w_type_nxt   = bus.i_in_type;
        w_bypass_nxt = !bus.i_run;
        w_rem_nxt    = '0;
        w_state_nxt  = bus.i_run ? INIT : DONE;
      end
      INIT: begin
        w_cnt_nxt   = r_type ? DP_LAST : SP_LAST;
        w_idx_nxt   = '0;
        w_state_nxt = ITER;
      end
      ITER: if (r_cnt == '0) w_state_nxt = NORM;
      else if (w_early) begin
        w_rem_nxt   = r_cnt;
        w_state_nxt = NORM;
      end else begin
        w_cnt_nxt = r_cnt - 1'b1;
        w_idx_nxt = r_idx + 1'b1;
      end
      NORM: w_state_nxt = DONE;
      DONE: w_state_nxt = bus.i_out_ack ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end
  assign bus.o_ready     = r_state == IDLE;
  assign bus.o_ld_reg    = (r_state == IDLE) && bus.i_start;
  assign bus.o_core_init = r_state == INIT;
  assign bus.o_core_step = r_state == ITER;
  assign bus.o_res_ld    = r_state == NORM;
  assign bus.o_out_valid = r_state == DONE;
  assign bus.o_busy      = r_state != IDLE;
  assign bus.o_step_idx  = r_idx;
  assign bus.o_rem_steps = r_rem;
  assign bus.o_type_q    = r_type;
  assign bus.o_bypass    = r_bypass;
endmodule

// File: tb/tb_sqrt_controller.sv
// tb_sqrt_controller: directed checks of sqrt_controller sequencing and latency
module tb_sqrt_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int n_init, n_step, n_res, lat, idx_err;
  bit found;
  sqrt_controller_if #(.CNT_W(6)) bus ();
  sqrt_controller #(.SP_ITERS(25), .DP_ITERS(54), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic t, input logic rn, input int zidx,
                       output int ni, output int ns, output int nr, output int lt, output int ie);
    ni = 0; ns = 0; nr = 0; lt = -1; ie = 0;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_run = rn; bus.i_in_type = t; bus.i_core_zero_rem = 1'b0;
    #1;
    chk("ld_reg_accept", {31'd0, bus.o_ld_reg}, 1);
    for (int c = 1; c <= 100 && lt < 0; c++) begin
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_run = 1'b0;
      #1;
      if (bus.o_core_init) ni++;
      if (bus.o_core_step) begin
        if (int'(bus.o_step_idx) != ns) ie++;
        ns++;
      end
      if (bus.o_res_ld) nr++;
      if (bus.o_out_valid) lt = c;
      bus.i_core_zero_rem = bus.o_core_step && (int'(bus.o_step_idx) == zidx);
    end
    bus.i_core_zero_rem = 1'b0;
  endtask
  task automatic do_ack();
    @(negedge clk);
    bus.i_out_ack = 1'b1;
    @(negedge clk);
    bus.i_out_ack = 1'b0;
    #1;
  endtask
  initial begin
    bus.i_start = 1'b0; bus.i_in_type = 1'b0; bus.i_run = 1'b0;
    bus.i_out_ack = 1'b0; bus.i_core_zero_rem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {bus.i_start, bus.i_in_type, bus.i_run, bus.i_out_ack, bus.i_core_zero_rem} = 5'($urandom);
      #1;
      chk("rst_ready", {31'd0, bus.o_ready}, 1);
      chk("rst_busy", {31'd0, bus.o_busy}, 0);
      chk("rst_valid", {31'd0, bus.o_out_valid}, 0);
      chk("rst_idx", {26'd0, bus.o_step_idx}, 0);
    end
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_run = 1'b0; bus.i_out_ack = 1'b0; bus.i_core_zero_rem = 1'b0;
    rst_n = 1'b1;
    do_op(1'b1, 1'b1, -1, n_init, n_step, n_res, lat, idx_err);
    chk("dp_init", n_init, 1);
    chk("dp_steps", n_step, 54);
    chk("dp_idx", idx_err, 0);
    chk("dp_res_ld", n_res, 1);
    chk("dp_latency", lat, 57);
    chk("dp_type_q", {31'd0, bus.o_type_q}, 1);
    chk("dp_bypass", {31'd0, bus.o_bypass}, 0);
    chk("dp_rem", {26'd0, bus.o_rem_steps}, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("dp_hold_valid", {31'd0, bus.o_out_valid}, 1);
    chk("dp_hold_ready", {31'd0, bus.o_ready}, 0);
    do_ack();
    chk("dp_ack_idle", {31'd0, bus.o_ready}, 1);
    chk("dp_ack_valid", {31'd0, bus.o_out_valid}, 0);
    do_op(1'b0, 1'b1, -1, n_init, n_step, n_res, lat, idx_err);
    chk("sp_steps", n_step, 25);
    chk("sp_idx", idx_err, 0);
    chk("sp_latency", lat, 28);
    chk("sp_type_q", {31'd0, bus.o_type_q}, 0);
    do_ack();
    do_op(1'b1, 1'b0, -1, n_init, n_step, n_res, lat, idx_err);
    chk("byp_latency", lat, 1);
    chk("byp_core", n_init + n_step + n_res, 0);
    chk("byp_flag", {31'd0, bus.o_bypass}, 1);
    chk("byp_type_q", {31'd0, bus.o_type_q}, 1);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_run = 1'b1; bus.i_in_type = 1'b0;
    #1;
    chk("done_ld_reg", {31'd0, bus.o_ld_reg}, 0);
    chk("done_ready", {31'd0, bus.o_ready}, 0);
    bus.i_out_ack = 1'b1;
    @(negedge clk);
    bus.i_out_ack = 1'b0;
    #1;
    chk("post_ack_ready", {31'd0, bus.o_ready}, 1);
    chk("post_ack_ld_reg", {31'd0, bus.o_ld_reg}, 1);
    chk("post_ack_busy", {31'd0, bus.o_busy}, 0);
    bus.i_start = 1'b0; bus.i_run = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_run = 1'b1; bus.i_in_type = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_run = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      #1;
      found = bus.o_core_step && bus.o_step_idx == 6'd20;
    end
    chk("mid_reach_20", {31'd0, found}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, bus.o_ready}, 1);
    chk("mid_rst_busy", {31'd0, bus.o_busy}, 0);
    chk("mid_rst_step", {31'd0, bus.o_core_step}, 0);
    chk("mid_rst_idx", {26'd0, bus.o_step_idx}, 0);
    chk("mid_rst_type", {31'd0, bus.o_type_q}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 1'b1, -1, n_init, n_step, n_res, lat, idx_err);
    chk("mid_rerun_latency", lat, 57);
    do_ack();
    do_op(1'b1, 1'b1, 10, n_init, n_step, n_res, lat, idx_err);
`ifdef SQRT_CTRL_EARLY_EXIT_EN
    chk("ee_steps", n_step, 11);
    chk("ee_latency", lat, 14);
    chk("ee_rem", {26'd0, bus.o_rem_steps}, 43);
`else
    chk("ee_steps", n_step, 54);
    chk("ee_latency", lat, 57);
    chk("ee_rem", {26'd0, bus.o_rem_steps}, 0);
`endif
    chk("ee_res_ld", n_res, 1);
    do_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
